// File: rtl/neonfox_regfile_p_if.sv
// neonfox_regfile_p_if: register-file bus between decode (master) and the register file (slave).
interface neonfox_regfile_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  localparam int NB = DATA_W / 8;
  logic                  stall;
  logic                  wren;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_data;
  logic [NB-1:0]         w_be;
  logic [ADDR_W-1:0]     a_addr;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     a_data;
  logic [DATA_W-1:0]     b_data;
  logic                  dio_sel;
  logic [DATA_W-1:0]     dio_in;
  logic                  data_access;
  logic [2*DATA_W-1:0]   last_callx_addr;
  logic [2*DATA_W-1:0]   next_callx_addr;
  logic [2*DATA_W-1:0]   data_address;
  logic [DATA_W-1:0]     io_address;
  modport master (
    output stall, wren, w_addr, w_data, w_be, a_addr, b_addr, dio_sel, dio_in, data_access, last_callx_addr,
    input  a_data, b_data, next_callx_addr, data_address, io_address
  );
  modport slave (
    input  stall, wren, w_addr, w_data, w_be, a_addr, b_addr, dio_sel, dio_in, data_access, last_callx_addr,
    output a_data, b_data, next_callx_addr, data_address, io_address
  );
endinterface

// File: rtl/neonfox_regfile_p.sv
// neonfox_regfile_p: NeonFox GPR/special register file with two forwarded read ports and write-through pointers.
// Define REGFILE_AUTOINC_EN to enable post-increment of {dah,dal} on data_access.
module neonfox_regfile_p #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int NUM_GPR = 16,
  parameter int DA_INC  = 1
) (
  input logic               clk,
  input logic               rst,
  neonfox_regfile_p_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int SB = (1 << ADDR_W) - 8;
  localparam int GW = NUM_GPR > 1 ? $clog2(NUM_GPR) : 1;
  localparam logic [ADDR_W-1:0] A_NG  = ADDR_W'(NUM_GPR);
  localparam logic [ADDR_W-1:0] A_DAL = ADDR_W'(SB);
  localparam logic [ADDR_W-1:0] A_DAH = ADDR_W'(SB + 1);
  localparam logic [ADDR_W-1:0] A_IAL = ADDR_W'(SB + 2);
  logic [DATA_W-1:0] r_gpr [NUM_GPR];
  logic [DATA_W-1:0] r_spr [8];
  logic [ADDR_W-1:0] r_a_addr, r_b_addr, r_pw_addr;
  logic [DATA_W-1:0] r_a_val, r_b_val, r_pw_data;
  logic [NB-1:0]     r_pw_be;
  logic              r_pw_en, r_dio;
  logic              w_wr, w_inc, w_cur_a, w_cur_b, w_prv_a, w_prv_b;
  logic [DATA_W-1:0] w_a_raw, w_b_raw, w_cx_lo, w_cx_hi;
  function automatic logic is_spr(input logic [ADDR_W-1:0] ad);
    return &ad[ADDR_W-1:3];
  endfunction
  // cal/cah are writable but their read path is the live return address, so never forwarded
  function automatic logic fwd_ok(input logic [ADDR_W-1:0] ad);
    return ad < A_NG || (is_spr(ad) && !(ad[2:0] inside {3'd3, 3'd4, 3'd5}));
  endfunction
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] ad);
    return ad < A_NG ? r_gpr[ad[GW-1:0]] :
           !is_spr(ad) ? '0 :
           ad[2:0] == 3'd3 ? '0 :
           ad[2:0] == 3'd4 ? w_cx_lo :
           ad[2:0] == 3'd5 ? w_cx_hi : r_spr[ad[2:0]];
  endfunction
  assign {w_cx_hi, w_cx_lo} = bus.last_callx_addr;
  assign w_wr    = bus.wren & ~bus.stall & ~rst;
  assign w_a_raw = rd(bus.a_addr);
  assign w_b_raw = rd(bus.b_addr);
  assign w_cur_a = w_wr && bus.w_addr == r_a_addr && fwd_ok(r_a_addr);
  assign w_cur_b = w_wr && bus.w_addr == r_b_addr && fwd_ok(r_b_addr);
  assign w_prv_a = r_pw_en && r_pw_addr == r_a_addr && fwd_ok(r_a_addr);
  assign w_prv_b = r_pw_en && r_pw_addr == r_b_addr && fwd_ok(r_b_addr);
`ifdef REGFILE_AUTOINC_EN
  // an explicit pointer write in the same cycle wins over the increment
  assign w_inc = bus.data_access & ~(w_wr && (bus.w_addr == A_DAL || bus.w_addr == A_DAH));
`else
  logic w_unused;
  assign w_unused = bus.data_access;
  assign w_inc    = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
      for (int i = 0; i < 8; i++) r_spr[i] <= '0;
      r_a_addr  <= '0;
      r_b_addr  <= '0;
      r_a_val   <= '0;
      r_b_val   <= '0;
      r_pw_en   <= 1'b0;
      r_pw_addr <= '0;
      r_pw_data <= '0;
      r_pw_be   <= '0;
      r_dio     <= 1'b0;
    end else if (!bus.stall) begin
      r_a_addr  <= bus.a_addr;
      r_b_addr  <= bus.b_addr;
      r_a_val   <= w_a_raw;
      r_b_val   <= w_b_raw;
      r_pw_en   <= bus.wren;
      r_pw_addr <= bus.w_addr;
      r_pw_data <= bus.w_data;
      r_pw_be   <= bus.w_be;
      r_dio     <= bus.dio_sel;
      if (w_inc) {r_spr[1], r_spr[0]} <= {r_spr[1], r_spr[0]} + (2*DATA_W)'(DA_INC);
      for (int i = 0; i < NB; i++)
        if (bus.wren && bus.w_be[i]) begin
          if (bus.w_addr < A_NG) r_gpr[bus.w_addr[GW-1:0]][8*i +: 8] <= bus.w_data[8*i +: 8];
          else if (is_spr(bus.w_addr) && bus.w_addr[2:0] != 3'd3) r_spr[bus.w_addr[2:0]][8*i +: 8] <= bus.w_data[8*i +: 8];
        end
    end
  end
  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign bus.a_data[8*g +: 8] = r_dio ? bus.dio_in[8*g +: 8] :
                                  (w_cur_a && bus.w_be[g]) ? bus.w_data[8*g +: 8] :
                                  (w_prv_a && r_pw_be[g]) ? r_pw_data[8*g +: 8] : r_a_val[8*g +: 8];
    assign bus.b_data[8*g +: 8] = (w_cur_b && bus.w_be[g]) ? bus.w_data[8*g +: 8] :
                                  (w_prv_b && r_pw_be[g]) ? r_pw_data[8*g +: 8] : r_b_val[8*g +: 8];
    assign bus.data_address[8*g +: 8] = (w_wr && bus.w_addr == A_DAL && bus.w_be[g]) ? bus.w_data[8*g +: 8] : r_spr[0][8*g +: 8];
    assign bus.data_address[DATA_W+8*g +: 8] = (w_wr && bus.w_addr == A_DAH && bus.w_be[g]) ? bus.w_data[8*g +: 8] : r_spr[1][8*g +: 8];
    assign bus.io_address[8*g +: 8] = (w_wr && bus.w_addr == A_IAL && bus.w_be[g]) ? bus.w_data[8*g +: 8] : r_spr[2][8*g +: 8];
  end
  assign bus.next_callx_addr = {r_spr[5], r_spr[4]};
endmodule

// File: tb/tb_neonfox_regfile_p.sv
// tb_neonfox_regfile_p: directed and randomized checks of neonfox_regfile_p against a behavioural register model.
module tb_neonfox_regfile_p;
  localparam int DW = 16, AW = 5, NG = 16, SB = 24, NB = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  neonfox_regfile_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  neonfox_regfile_p #(.DATA_W(DW), .ADDR_W(AW), .NUM_GPR(NG), .DA_INC(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
  } wr_t;
  int n_run = 0, n_fail = 0;
  logic [DW-1:0] mem [32];
  logic [AW-1:0] m_ra, m_rb;
  logic [DW-1:0] m_rav, m_rbv;
  logic          m_dio;
  wr_t           m_pw;
  function automatic bit fwd(input int x);
    return x < NG || x == SB || x == SB + 1 || x == SB + 2 || x >= SB + 6;
  endfunction
  function automatic bit wrt(input int x);
    return x < NG || (x >= SB && x != SB + 3);
  endfunction
  function automatic logic [DW-1:0] raw(input int x);
    if (x == SB + 4) return bus.last_callx_addr[DW-1:0];
    if (x == SB + 5) return bus.last_callx_addr[2*DW-1:DW];
    return fwd(x) ? mem[x] : '0;
  endfunction
  function automatic logic [DW-1:0] ovl(input logic [DW-1:0] v, input int x, input wr_t w);
    for (int i = 0; i < NB; i++) if (w.en && int'(w.addr) == x && w.be[i]) v[8*i +: 8] = w.data[8*i +: 8];
    return v;
  endfunction
  function automatic wr_t cur();
    wr_t w;
    w.en = bus.wren && !bus.stall && !rst;
    w.addr = bus.w_addr;
    w.data = bus.w_data;
    w.be = bus.w_be;
    return w;
  endfunction
  // a read sees its snapshot, then the previous write, then the write in flight
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input logic [DW-1:0] v);
    return fwd(int'(a)) ? ovl(ovl(v, int'(a), m_pw), int'(a), cur()) : v;
  endfunction
  function automatic logic [DW-1:0] exp_a();
    return m_dio ? bus.dio_in : exp_rd(m_ra, m_rav);
  endfunction
  function automatic logic [2*DW-1:0] exp_da();
    return {ovl(mem[SB+1], SB + 1, cur()), ovl(mem[SB], SB, cur())};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    m_ra = '0; m_rb = '0; m_rav = '0; m_rbv = '0; m_dio = 1'b0; m_pw = '0;
  endtask
  task automatic step();
    logic inc;
    @(posedge clk);
    if (!rst && !bus.stall) begin
      inc = 1'b0;
`ifdef REGFILE_AUTOINC_EN
      inc = bus.data_access && !(bus.wren && (int'(bus.w_addr) == SB || int'(bus.w_addr) == SB + 1));
`endif
      m_rav = raw(int'(bus.a_addr));
      m_rbv = raw(int'(bus.b_addr));
      m_ra = bus.a_addr;
      m_rb = bus.b_addr;
      m_dio = bus.dio_sel;
      m_pw.en = bus.wren; m_pw.addr = bus.w_addr; m_pw.data = bus.w_data; m_pw.be = bus.w_be;
      if (inc) {mem[SB+1], mem[SB]} = {mem[SB+1], mem[SB]} + 32'd1;
      if (bus.wren && wrt(int'(bus.w_addr))) mem[bus.w_addr] = ovl(mem[bus.w_addr], int'(bus.w_addr), m_pw);
    end
    #1;
  endtask
  task automatic idle();
    bus.stall = 0; bus.wren = 0; bus.w_addr = '0; bus.w_data = '0; bus.w_be = '0;
    bus.dio_sel = 0; bus.data_access = 0;
  endtask
  task automatic wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    bus.wren = 1; bus.w_addr = AW'(a); bus.w_data = d; bus.w_be = be;
  endtask
  task automatic test_reset();
    rst = 1;
    idle();
    bus.a_addr = '0; bus.b_addr = '0; bus.dio_in = 16'h1357; bus.last_callx_addr = '0;
    wr(0, 16'h9abc, 2'b11);
    model_reset();
    step(); step();
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'h0) begin n_fail++; $display("FAIL reset_a got %h exp 0", bus.a_data); end
    n_run++; if (bus.b_data !== 16'h0) begin n_fail++; $display("FAIL reset_b got %h exp 0", bus.b_data); end
    n_run++; if (bus.data_address !== 32'h0) begin n_fail++; $display("FAIL reset_da got %h exp 0", bus.data_address); end
    n_run++; if (bus.io_address !== 16'h0) begin n_fail++; $display("FAIL reset_io got %h exp 0", bus.io_address); end
    n_run++; if (bus.next_callx_addr !== 32'h0) begin n_fail++; $display("FAIL reset_cx got %h exp 0", bus.next_callx_addr); end
    step();
    rst = 0;
    idle();
    step();
  endtask
  task automatic test_basic();
    idle(); wr(3, 16'hA5C3, 2'b11);
    step();
    idle();
    step();
    bus.a_addr = 5'd3; bus.b_addr = AW'(SB + 3);
    step();
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'hA5C3) begin n_fail++; $display("FAIL basic_a got %h exp a5c3", bus.a_data); end
    n_run++; if (bus.b_data !== 16'h0) begin n_fail++; $display("FAIL basic_rsvd got %h exp 0", bus.b_data); end
    step();
  endtask
  task automatic test_fwd();
    idle(); wr(5, 16'h1234, 2'b11);
    bus.a_addr = 5'd5; bus.b_addr = 5'd5;
    step();
    wr(5, 16'hFF00, 2'b10);
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'hFF34) begin n_fail++; $display("FAIL fwd_cur_prev_a got %h exp ff34", bus.a_data); end
    n_run++; if (bus.b_data !== 16'hFF34) begin n_fail++; $display("FAIL fwd_cur_prev_b got %h exp ff34", bus.b_data); end
    step();
    idle();
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'hFF34) begin n_fail++; $display("FAIL fwd_prev_a got %h exp ff34", bus.a_data); end
    step();
  endtask
  task automatic test_dio();
    idle(); wr(5, 16'h0077, 2'b01);
    bus.dio_sel = 1; bus.a_addr = 5'd5; bus.b_addr = 5'd5;
    step();
    idle(); bus.dio_in = 16'hBEEF;
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'hBEEF) begin n_fail++; $display("FAIL dio_a got %h exp beef", bus.a_data); end
    n_run++; if (bus.b_data !== 16'hFF77) begin n_fail++; $display("FAIL dio_b got %h exp ff77", bus.b_data); end
    step();
  endtask
  task automatic test_stall();
    idle(); wr(1, 16'h1111, 2'b11);
    step();
    idle(); bus.a_addr = 5'd3; bus.b_addr = 5'd5;
    step(); step();
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'hA5C3) begin n_fail++; $display("FAIL stall_pre_a got %h exp a5c3", bus.a_data); end
    step();
    bus.stall = 1; wr(1, 16'h5555, 2'b11); bus.a_addr = 5'd1; bus.b_addr = 5'd1; bus.dio_sel = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++; if (bus.a_data !== 16'hA5C3) begin n_fail++; $display("FAIL stall_hold_a c%0d got %h exp a5c3", c, bus.a_data); end
      n_run++; if (bus.b_data !== 16'hFF77) begin n_fail++; $display("FAIL stall_hold_b c%0d got %h exp ff77", c, bus.b_data); end
      step();
    end
    idle(); bus.a_addr = 5'd1;
    step();
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'h1111) begin n_fail++; $display("FAIL stall_r1 got %h exp 1111", bus.a_data); end
    step();
  endtask
  task automatic test_autoinc();
    logic [31:0] e;
    idle(); wr(SB + 1, 16'h0000, 2'b11);
    step();
    wr(SB, 16'hFFFF, 2'b11);
    @(negedge clk);
    n_run++; if (bus.data_address !== 32'h0000FFFF) begin n_fail++; $display("FAIL da_writethru got %h exp 0000ffff", bus.data_address); end
    step();
    idle(); bus.data_access = 1;
    step();
    idle();
`ifdef REGFILE_AUTOINC_EN
    e = 32'h00010000;
`else
    e = 32'h0000FFFF;
`endif
    @(negedge clk);
    n_run++; if (bus.data_address !== e) begin n_fail++; $display("FAIL da_inc got %h exp %h", bus.data_address, e); end
    step();
    wr(SB + 1, 16'h0000, 2'b11);
    step();
    wr(SB, 16'h0100, 2'b11); bus.data_access = 1;
    step();
    idle();
    @(negedge clk);
    n_run++; if (bus.data_address !== 32'h00000100) begin n_fail++; $display("FAIL da_write_wins got %h exp 00000100", bus.data_address); end
    step();
    wr(SB + 1, 16'hFFFF, 2'b11);
    step();
    wr(SB, 16'hFFFF, 2'b11);
    step();
    idle(); bus.data_access = 1;
    step();
    idle();
`ifdef REGFILE_AUTOINC_EN
    e = 32'h00000000;
`else
    e = 32'hFFFFFFFF;
`endif
    @(negedge clk);
    n_run++; if (bus.data_address !== e) begin n_fail++; $display("FAIL da_wrap got %h exp %h", bus.data_address, e); end
    step();
    wr(SB + 2, 16'hC0DE, 2'b01);
    @(negedge clk);
    n_run++; if (bus.io_address !== 16'h00DE) begin n_fail++; $display("FAIL io_writethru got %h exp 00de", bus.io_address); end
    step();
    idle();
    @(negedge clk);
    n_run++; if (bus.io_address !== 16'h00DE) begin n_fail++; $display("FAIL io_stored got %h exp 00de", bus.io_address); end
    step();
  endtask
  task automatic test_async_reset();
    idle(); wr(SB + 4, 16'hAAAA, 2'b11);
    step();
    wr(SB + 5, 16'hBBBB, 2'b11);
    step();
    idle();
    @(negedge clk);
    n_run++; if (bus.next_callx_addr !== 32'hBBBBAAAA) begin n_fail++; $display("FAIL callx got %h exp bbbbaaaa", bus.next_callx_addr); end
    step();
    bus.a_addr = 5'd3; bus.b_addr = 5'd5;
    for (int c = 0; c < 3; c++) begin
      wr(c, DW'($urandom), 2'b11);
      step();
    end
    wr(3, 16'h4242, 2'b11);
    @(negedge clk);
    #1 rst = 1;
    model_reset();
    #1;
    n_run++; if (bus.a_data !== 16'h0) begin n_fail++; $display("FAIL arst_a got %h exp 0", bus.a_data); end
    n_run++; if (bus.b_data !== 16'h0) begin n_fail++; $display("FAIL arst_b got %h exp 0", bus.b_data); end
    n_run++; if (bus.data_address !== 32'h0) begin n_fail++; $display("FAIL arst_da got %h exp 0", bus.data_address); end
    n_run++; if (bus.io_address !== 16'h0) begin n_fail++; $display("FAIL arst_io got %h exp 0", bus.io_address); end
    n_run++; if (bus.next_callx_addr !== 32'h0) begin n_fail++; $display("FAIL arst_cx got %h exp 0", bus.next_callx_addr); end
    step();
    rst = 0;
    idle();
    bus.a_addr = AW'(SB + 4); bus.b_addr = AW'(SB + 5); bus.last_callx_addr = 32'h12345678;
    step();
    @(negedge clk);
    n_run++; if (bus.a_data !== 16'h5678) begin n_fail++; $display("FAIL lcx_lo got %h exp 5678", bus.a_data); end
    n_run++; if (bus.b_data !== 16'h1234) begin n_fail++; $display("FAIL lcx_hi got %h exp 1234", bus.b_data); end
    step();
  endtask
  function automatic logic [AW-1:0] pick();
    case ($urandom % 4)
      0, 1:    return AW'($urandom % 4);
      2:       return AW'(SB + $urandom % 8);
      default: return AW'($urandom % 32);
    endcase
  endfunction
  task automatic test_random();
    logic [DW-1:0] ea, eb, ei;
    logic [2*DW-1:0] ed, ec;
    for (int c = 0; c < 400; c++) begin
      bus.stall = ($urandom % 8) == 0;
      bus.wren = $urandom % 2;
      bus.w_addr = pick();
      bus.w_data = DW'($urandom);
      bus.w_be = NB'($urandom);
      bus.a_addr = pick();
      bus.b_addr = pick();
      bus.dio_sel = ($urandom % 8) == 0;
      bus.dio_in = DW'($urandom);
      bus.data_access = ($urandom % 4) == 0;
      bus.last_callx_addr = $urandom;
      @(negedge clk);
      ea = exp_a();
      eb = exp_rd(m_rb, m_rbv);
      ed = exp_da();
      ei = ovl(mem[SB+2], SB + 2, cur());
      ec = {mem[SB+5], mem[SB+4]};
      n_run++; if (bus.a_data !== ea) begin n_fail++; $display("FAIL rand_a c%0d got %h exp %h", c, bus.a_data, ea); end
      n_run++; if (bus.b_data !== eb) begin n_fail++; $display("FAIL rand_b c%0d got %h exp %h", c, bus.b_data, eb); end
      n_run++; if (bus.data_address !== ed) begin n_fail++; $display("FAIL rand_da c%0d got %h exp %h", c, bus.data_address, ed); end
      n_run++; if (bus.io_address !== ei) begin n_fail++; $display("FAIL rand_io c%0d got %h exp %h", c, bus.io_address, ei); end
      n_run++; if (bus.next_callx_addr !== ec) begin n_fail++; $display("FAIL rand_cx c%0d got %h exp %h", c, bus.next_callx_addr, ec); end
      step();
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_fwd();
    test_dio();
    test_stall();
    test_autoinc();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
